// File: rtl/difficulty_ramp.sv
// Score-driven difficulty controller: level, ramped scroll speed and minimum spawn gap.
// Optional spawn-gap jitter from an LFSR input is enabled by defining DIFFICULTY_RAMP_JITTER_EN.
module difficulty_ramp #(
    parameter int MIN_SPEED   = 1,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 30,
    parameter int BASE_GAP    = 60,
    parameter int GAP_DEC     = 8,
    parameter int MIN_GAP     = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_game_start_pulse,
    input  logic        i_game_frozen,
    input  logic        i_game_tick,
    input  logic [15:0] i_score,
`ifdef DIFFICULTY_RAMP_JITTER_EN
    input  logic [7:0]  i_rng,
`endif
    output logic [2:0]  o_speed,
    output logic [6:0]  o_min_gap,
    output logic [3:0]  o_level,
    output logic        o_level_up_pulse
);

    localparam int CNT_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_TICKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [3:0]       level_q, level_d;
    logic [2:0]       speed_q, speed_d;
    logic [6:0]       gap_q, gap_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] accel_cnt_q, accel_cnt_d;

    logic [3:0]        target_level;
    logic [2:0]        target_speed;
    logic [6:0]        gap_calc;
    logic [6:0]        gap_next;
    logic signed [11:0] gap_raw;

    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [3:0] level_from_score(input logic [3:0] th, input logic [3:0] hu);
        logic [6:0] raw;
        raw = 7'(sat_digit(th)) * 7'd10 + 7'(sat_digit(hu));
        return (raw > 7'd15) ? 4'd15 : raw[3:0];
    endfunction

    function automatic logic [2:0] speed_for_level(input logic [3:0] lvl);
        logic [3:0] raw;
        raw = 4'(MIN_SPEED) + {2'b00, lvl[3:2]};
        return (raw > 4'(MAX_SPEED)) ? 3'(MAX_SPEED) : raw[2:0];
    endfunction

    logic unused_score;
    assign unused_score = ^i_score[7:0];

    assign target_level = level_from_score(i_score[15:12], i_score[11:8]);
    assign target_speed = speed_for_level(level_q);

    // Widened signed subtraction so deep levels go negative instead of wrapping.
    assign gap_raw  = 12'(BASE_GAP) - 12'(GAP_DEC) * {8'd0, level_q};
    assign gap_calc = (gap_raw < $signed(12'(MIN_GAP))) ? 7'(MIN_GAP) : gap_raw[6:0];

`ifdef DIFFICULTY_RAMP_JITTER_EN
    logic [7:0] jit_sum;
    logic       unused_rng;
    assign unused_rng = ^i_rng[7:3];
    assign jit_sum    = {1'b0, gap_calc} + {5'd0, i_rng[2:0]};
    assign gap_next   = jit_sum[7] ? 7'd127 : jit_sum[6:0];
`else
    assign gap_next   = gap_calc;
`endif

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        speed_d     = speed_q;
        gap_d       = gap_q;
        accel_cnt_d = accel_cnt_q;
        pulse_d     = 1'b0;
        if (i_game_start_pulse) begin
            state_d     = RUN;
            level_d     = 4'd0;
            speed_d     = 3'(MIN_SPEED);
            gap_d       = 7'(BASE_GAP);
            accel_cnt_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    gap_d = gap_next;
                    if (i_game_frozen) begin
                        state_d = HOLD;
                    end else if (i_game_tick) begin
                        if (level_q < target_level) begin
                            level_d = level_q + 4'd1;
                            pulse_d = 1'b1;
                        end
                        if (speed_q < target_speed) begin
                            if (accel_cnt_q == CNT_LAST) begin
                                speed_d     = speed_q + 3'd1;
                                accel_cnt_d = '0;
                            end else begin
                                accel_cnt_d = accel_cnt_q + 1'b1;
                            end
                        end else begin
                            accel_cnt_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            level_q     <= 4'd0;
            speed_q     <= 3'(MIN_SPEED);
            gap_q       <= 7'(BASE_GAP);
            accel_cnt_q <= '0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            speed_q     <= speed_d;
            gap_q       <= gap_d;
            accel_cnt_q <= accel_cnt_d;
            pulse_q     <= pulse_d;
        end
    end

    assign o_speed          = speed_q;
    assign o_min_gap        = gap_q;
    assign o_level          = level_q;
    assign o_level_up_pulse = pulse_q;

endmodule

// File: tb/tb_difficulty_ramp.sv
// Directed bench for difficulty_ramp: reset, level/speed ramps, freeze, priority, jitter.
// Define DIFFICULTY_RAMP_JITTER_EN to build and exercise the jitter variant.
module tb_difficulty_ramp;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        frozen;
    logic        tick;
    logic [15:0] score;
    logic [7:0]  rng;
    logic [2:0]  speed;
    logic [6:0]  min_gap;
    logic [3:0]  level;
    logic        lvl_pulse;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    difficulty_ramp dut (
        .clk                (clk),
        .rst                (rst),
        .i_game_start_pulse (start),
        .i_game_frozen      (frozen),
        .i_game_tick        (tick),
        .i_score            (score),
`ifdef DIFFICULTY_RAMP_JITTER_EN
        .i_rng              (rng),
`endif
        .o_speed            (speed),
        .o_min_gap          (min_gap),
        .o_level            (level),
        .o_level_up_pulse   (lvl_pulse)
    );

    always @(negedge clk) if (lvl_pulse) pulse_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One tick pulse, then one idle cycle so o_min_gap has caught up with o_level.
    task automatic do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    int last_step, min_int, max_spd;
    logic [2:0] prev_spd;

    initial begin
        rst = 1'b1; start = 1'b0; frozen = 1'b0; tick = 1'b0;
        score = 16'h0000; rng = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // T1 reset values and ignored ticks in IDLE
        chk("rst_speed", speed, 1);
        chk("rst_gap", min_gap, 60);
        chk("rst_level", level, 0);
        chk("rst_pulse", lvl_pulse, 0);
        score = 16'h9999;
        repeat (3) do_tick();
        chk("idle_level", level, 0);
        chk("idle_speed", speed, 1);
        chk("idle_gap", min_gap, 60);

        // T2 level ramp
        score = 16'h0300;
        do_start();
        pulse_cnt = 0;
        do_tick(); chk("t2_lvl1", level, 1); chk("t2_gap1", min_gap, 52);
        do_tick(); chk("t2_lvl2", level, 2);
        do_tick(); chk("t2_lvl3", level, 3);
        do_tick(); chk("t2_lvl4", level, 3);
        chk("t2_pulses", pulse_cnt, 3);
        chk("t2_gap", min_gap, 36);
        chk("t2_speed", speed, 1);

        // T3 first part, then T4 freeze at speed 2
        score = 16'h2000;
        do_start();
        for (int k = 1; k <= 34; k++) begin
            do_tick();
            if (k == 15) begin
                chk("t3_lvl15", level, 15);
                chk("t3_gap15", min_gap, 24);
            end
            if (k == 33) chk("t3_spd33", speed, 1);
        end
        chk("t3_spd34", speed, 2);
        frozen = 1'b1;
        pulse_cnt = 0;
        repeat (100) do_tick();
        chk("t4_speed", speed, 2);
        chk("t4_level", level, 15);
        chk("t4_gap", min_gap, 24);
        chk("t4_pulses", pulse_cnt, 0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0; frozen = 1'b0;
        chk("t4_rs_speed", speed, 1);
        chk("t4_rs_level", level, 0);
        chk("t4_rs_gap", min_gap, 60);

        // T3 full speed ramp
        do_start();
        last_step = 0; min_int = 1000; max_spd = 0; prev_spd = speed;
        for (int k = 1; k <= 130; k++) begin
            do_tick();
            if (speed != prev_spd) begin
                if (k - last_step < min_int) min_int = k - last_step;
                last_step = k;
                prev_spd = speed;
            end
            if (int'(speed) > max_spd) max_spd = int'(speed);
            if (k == 63) chk("t3_spd63", speed, 2);
            if (k == 64) chk("t3_spd64", speed, 3);
            if (k == 93) chk("t3_spd93", speed, 3);
            if (k == 94) chk("t3_spd94", speed, 4);
        end
        chk("t3_spd_end", speed, 4);
        chk("t3_spd_max", max_spd, 4);
        chk("t3_step_int", min_int, 30);

        // T5 start+tick priority, monotonic level, invalid digit
        score = 16'h0500;
        pulse_cnt = 0;
        @(negedge clk) begin start = 1'b1; tick = 1'b1; end
        @(negedge clk) begin start = 1'b0; tick = 1'b0; end
        @(negedge clk);
        chk("t5_prio_lvl", level, 0);
        chk("t5_prio_spd", speed, 1);
        chk("t5_prio_pulse", pulse_cnt, 0);
        repeat (6) do_tick();
        chk("t5_lvl5", level, 5);
        score = 16'h0100;
        repeat (3) do_tick();
        chk("t5_no_drop", level, 5);
        score = 16'h0F00;
        do_start();
        repeat (12) do_tick();
        chk("t5_bad_digit", level, 9);
        chk("t5_gap9", min_gap, 24);

        // Reset mid-run drops state and the pulse on that edge
        score = 16'h0300;
        do_start();
        @(negedge clk) begin tick = 1'b1; end
        @(negedge clk) begin tick = 1'b0; end
        chk("mid_pulse_hi", lvl_pulse, 1);
        @(negedge clk) begin tick = 1'b1; rst = 1'b1; end
        @(negedge clk) begin tick = 1'b0; rst = 1'b0; end
        chk("mid_rst_lvl", level, 0);
        chk("mid_rst_pulse", lvl_pulse, 0);
        chk("mid_rst_gap", min_gap, 60);

`ifdef DIFFICULTY_RAMP_JITTER_EN
        // T6 jitter
        score = 16'h0000; rng = 8'h07;
        do_start();
        @(negedge clk);
        chk("t6_lvl0_jit", min_gap, 67);
        score = 16'h2000; rng = 8'h03;
        repeat (15) do_tick();
        chk("t6_lvl15_jit", min_gap, 27);
        rng = 8'h00;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
